// File: rtl/sub16_pkg.sv
// Shared constants and state type for the bit-serial 16-bit subtractor.
package sub16_pkg;
  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_sub16.sv
// Bit-serial 16-bit subtractor, one bit per clock, LSB first.
// Optional zr/ng status flags are built when SERIAL_SUB16_FLAGS_EN is defined.
module serial_sub16
  import sub16_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
`ifdef SERIAL_SUB16_FLAGS_EN
  ,
  output logic             zr,
  output logic             ng
`endif
);
  localparam logic [CNT_W-1:0] CNT_LAST = 4'd15;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-2:0] w_q, w_d;
  logic             bin_q, bin_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic             zr_q, zr_d, ng_q, ng_d;
  logic             d_s, bout_s;
  logic             accept_s;
  logic [WIDTH-1:0] res_s;

  full_sub u_full_sub (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .bin (bin_q),
    .d   (d_s),
    .bout(bout_s)
  );

  // Next-state, datapath step and output-register update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    w_d      = w_q;
    bin_d    = bin_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zr_d     = zr_q;
    ng_d     = ng_q;
    accept_s = start & ready_q;
    res_s    = {d_s, w_q};

    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          state_d = RUN;
          a_d     = x;
          b_d     = y;
          w_d     = {(WIDTH-1){1'b0}};
          bin_d   = 1'b0;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        w_d   = {d_s, w_q[WIDTH-2:1]};
        bin_d = bout_s;
        cnt_d = cnt_q + 4'd1;
        // Counter wraps to zero on the same edge the result is published.
        if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          diff_d   = res_s;
          borrow_d = bout_s;
          zr_d     = (res_s == 16'h0000);
          ng_d     = res_s[WIDTH-1];
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE) || (state_d == DONE);
    busy_d  = (state_d == RUN);
    done_d  = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      w_q      <= {(WIDTH-1){1'b0}};
      bin_q    <= 1'b0;
      diff_q   <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
      zr_q     <= 1'b1;
      ng_q     <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      w_q      <= w_d;
      bin_q    <= bin_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zr_q     <= zr_d;
      ng_q     <= ng_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign Diff   = diff_q;
  assign Borrow = borrow_q;

`ifdef SERIAL_SUB16_FLAGS_EN
  assign zr = zr_q;
  assign ng = ng_q;
`else
  logic unused_flags_s;
  assign unused_flags_s = zr_q ^ ng_q;
`endif
endmodule
